// File: rtl/spi_arb_pkg.sv
// Shared state encoding and helpers for the SPI transaction arbiter.
// Included by spi_txn_arbiter and spi_rr_arbiter.
package spi_arb_pkg;

  localparam int DATA_W = 8;
  localparam int ST_W   = 4;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_LOAD     = 4'd1;
  localparam state_t ST_WR_WAIT  = 4'd2;
  localparam state_t ST_WR_ISSUE = 4'd3;
  localparam state_t ST_WR_REL   = 4'd4;
  localparam state_t ST_RD_ISSUE = 4'd5;
  localparam state_t ST_RD_REL   = 4'd6;
  localparam state_t ST_STOP     = 4'd7;
  localparam state_t ST_STOP_REL = 4'd8;
  localparam state_t ST_DONE     = 4'd9;

  // States in which the serializer, not the requester, owns progress.
  function automatic logic is_watched(input state_t st);
    case (st)
      ST_WR_ISSUE, ST_WR_REL, ST_RD_ISSUE,
      ST_RD_REL, ST_STOP, ST_STOP_REL: is_watched = 1'b1;
      default:                         is_watched = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: combinational winner search starting at the pointer;
// pointer moves to one past the winner when update_i is asserted.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             update_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_s, cand_idx_s;
  logic             found_s, hit_s;
  int               cand_s;

  // Winner search: first requester at or after the pointer, wrapping.
  always_comb begin
    found_s    = 1'b0;
    idx_s      = '0;
    cand_s     = 0;
    cand_idx_s = '0;
    hit_s      = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s     = int'(ptr_q) + k;
      cand_s     = (cand_s >= N) ? cand_s - N : cand_s;
      cand_idx_s = cand_s[IDX_W-1:0];
      hit_s      = req_i[cand_idx_s] & ~found_s;
      idx_s      = hit_s ? cand_idx_s : idx_s;
      found_s    = found_s | hit_s;
    end
  end

  // Pointer advance.
  always_comb begin
    if (update_i && found_s) begin
      ptr_d = (idx_s == IDX_W'(N-1)) ? '0 : idx_s + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign gnt_valid_o = found_s;
  assign gnt_idx_o   = idx_s;

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI serializer between NUM_REQ requesters, one locked transaction at a time.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                     Bus_CLK_i,
  input  logic                     RSTn_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [8*NUM_REQ-1:0]     req_cs_i,
  input  logic [LEN_W*NUM_REQ-1:0] req_wr_len_i,
  input  logic [LEN_W*NUM_REQ-1:0] req_rd_len_i,
  input  logic [8*NUM_REQ-1:0]     wr_data_i,
  input  logic [NUM_REQ-1:0]       wr_data_valid_i,
  output logic [NUM_REQ-1:0]       wr_data_ready_o,
  output logic [7:0]               rd_data_o,
  output logic [NUM_REQ-1:0]       rd_data_valid_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic                     start_o,
  output logic                     stop_o,
  output logic                     write_o,
  output logic                     read_o,
  output logic [7:0]               SPI_Write_Data_o,
  output logic [7:0]               SPI_CS_Reg_o,
  input  logic                     IRQ_write_i,
  input  logic                     IRQ_read_i,
  input  logic                     trnfer_cmplte_i,
  input  logic [7:0]               SPI_Read_Data_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [7:0]           cs_q, cs_d;
  logic [LEN_W-1:0]     wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic                 rd_lat_q, rd_lat_d;
  logic                 err_flag_q, err_flag_d;

  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d, wr_ready_q, wr_ready_d;
  logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d, done_q, done_d, err_q, err_d;
  logic                 start_q, start_d, stop_q, stop_d, write_q, write_d, read_q, read_d;
  logic [7:0]           cs_out_q, cs_out_d;

  logic                 grant_s, wr_take_s, rd_take_s, timeout_s, gnt_any_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic [NUM_REQ-1:0]   arb_req_s, gnt_oh_s;

  assign arb_req_s = (state_q == ST_IDLE) ? req_valid_i : '0;

  spi_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .clk         (Bus_CLK_i),
    .rst_n       (RSTn_i),
    .req_i       (arb_req_s),
    .update_i    (grant_s),
    .gnt_valid_o (gnt_any_s),
    .gnt_idx_o   (gnt_idx_s)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;

  // Watchdog: restarts on every state change, counts only in serializer-owned states.
  always_comb begin
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if (is_watched(state_q)) begin
      wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
    end else begin
      wd_cnt_d = '0;
    end
  end

  // Watchdog register.
  always_ff @(posedge Bus_CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) wd_cnt_q <= '0;
    else         wd_cnt_q <= wd_cnt_d;
  end

  assign timeout_s = is_watched(state_q) && (wd_cnt_q == '1);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and transaction datapath.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cs_d       = cs_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_lat_d   = rd_lat_q;
    err_flag_d = err_flag_q;
    grant_s    = 1'b0;
    wr_take_s  = 1'b0;
    rd_take_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any_s) begin
          grant_s    = 1'b1;
          gnt_d      = gnt_idx_s;
          cs_d       = req_cs_i[int'(gnt_idx_s)*8 +: 8];
          wr_cnt_d   = req_wr_len_i[int'(gnt_idx_s)*LEN_W +: LEN_W];
          rd_cnt_d   = req_rd_len_i[int'(gnt_idx_s)*LEN_W +: LEN_W];
          err_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (wr_cnt_q != '0)      state_d = ST_WR_WAIT;
        else if (rd_cnt_q != '0) state_d = ST_RD_ISSUE;
        else                     state_d = ST_DONE;
      end
      ST_WR_WAIT: begin
        if (wr_data_valid_i[gnt_q]) begin
          wr_take_s = 1'b1;
          wdata_d   = wr_data_i[int'(gnt_q)*8 +: 8];
          state_d   = ST_WR_ISSUE;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_WR_ISSUE: begin
        if (timeout_s) begin
          err_flag_d = 1'b1;
          state_d    = ST_STOP;
        end else if (IRQ_write_i) begin
          state_d = ST_WR_REL;
        end else begin
          state_d = ST_WR_ISSUE;
        end
      end
      ST_WR_REL: begin
        if (timeout_s) begin
          err_flag_d = 1'b1;
          state_d    = ST_STOP;
        end else if (!IRQ_write_i) begin
          wr_cnt_d = wr_cnt_q - LEN_W'(1);
          if (wr_cnt_q != LEN_W'(1)) state_d = ST_WR_WAIT;
          else if (rd_cnt_q != '0)   state_d = ST_RD_ISSUE;
          else                       state_d = ST_STOP;
        end else begin
          state_d = ST_WR_REL;
        end
      end
      ST_RD_ISSUE: begin
        if (timeout_s) begin
          err_flag_d = 1'b1;
          state_d    = ST_STOP;
        end else if (IRQ_read_i) begin
          state_d = ST_RD_REL;
        end else begin
          state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_REL: begin
        // The serializer's read latch settles one cycle after IRQ_read_i falls.
        if (timeout_s) begin
          err_flag_d = 1'b1;
          rd_lat_d   = 1'b0;
          state_d    = ST_STOP;
        end else if (rd_lat_q) begin
          rd_take_s = 1'b1;
          rdata_d   = SPI_Read_Data_i;
          rd_lat_d  = 1'b0;
          rd_cnt_d  = rd_cnt_q - LEN_W'(1);
          state_d   = (rd_cnt_q == LEN_W'(1)) ? ST_STOP : ST_RD_ISSUE;
        end else if (!IRQ_read_i) begin
          rd_lat_d = 1'b1;
        end else begin
          state_d = ST_RD_REL;
        end
      end
      ST_STOP: begin
        if (timeout_s) begin
          err_flag_d = 1'b1;
          state_d    = ST_DONE;
        end else if (trnfer_cmplte_i) begin
          state_d = ST_STOP_REL;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_STOP_REL: begin
        if (timeout_s) begin
          err_flag_d = 1'b1;
          state_d    = ST_DONE;
        end else if (!trnfer_cmplte_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STOP_REL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One-hot of the owning requester.
  always_comb begin
    gnt_oh_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh_s[i] = (gnt_d == IDX_W'(i));
    end
  end

  // Output decode from the upcoming state so every output comes straight from a flop.
  always_comb begin
    req_ready_d = grant_s   ? gnt_oh_s : '0;
    wr_ready_d  = wr_take_s ? gnt_oh_s : '0;
    rd_valid_d  = rd_take_s ? gnt_oh_s : '0;
    done_d      = (state_d == ST_DONE) ? gnt_oh_s : '0;
    err_d       = ((state_d == ST_DONE) && err_flag_d) ? gnt_oh_s : '0;
    start_d     = (state_d == ST_WR_ISSUE) || (state_d == ST_RD_ISSUE);
    write_d     = (state_d == ST_WR_ISSUE);
    read_d      = (state_d == ST_RD_ISSUE);
    stop_d      = (state_d == ST_STOP);
    cs_out_d    = (state_d == ST_IDLE) ? 8'h00 : cs_d;
  end

  // State and datapath registers.
  always_ff @(posedge Bus_CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      cs_q       <= 8'h00;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_lat_q   <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cs_q       <= cs_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_lat_q   <= rd_lat_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Output registers.
  always_ff @(posedge Bus_CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      req_ready_q <= '0;
      wr_ready_q  <= '0;
      rd_valid_q  <= '0;
      done_q      <= '0;
      err_q       <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      cs_out_q    <= 8'h00;
    end else begin
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      write_q     <= write_d;
      read_q      <= read_d;
      cs_out_q    <= cs_out_d;
    end
  end

  assign req_ready_o      = req_ready_q;
  assign wr_data_ready_o  = wr_ready_q;
  assign rd_data_valid_o  = rd_valid_q;
  assign rd_data_o        = rdata_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign start_o          = start_q;
  assign stop_o           = stop_q;
  assign write_o          = write_q;
  assign read_o           = read_q;
  assign SPI_Write_Data_o = wdata_q;
  assign SPI_CS_Reg_o     = cs_out_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a behavioural serializer and requester model.
module tb_spi_txn_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int LEN_W     = 8;
  localparam int TIMEOUT_W = 16;

  logic                     Bus_CLK_i = 1'b0;
  logic                     RSTn_i;
  logic [NUM_REQ-1:0]       req_valid_i, req_ready_o;
  logic [8*NUM_REQ-1:0]     req_cs_i;
  logic [LEN_W*NUM_REQ-1:0] req_wr_len_i, req_rd_len_i;
  logic [8*NUM_REQ-1:0]     wr_data_i;
  logic [NUM_REQ-1:0]       wr_data_valid_i, wr_data_ready_o;
  logic [7:0]               rd_data_o;
  logic [NUM_REQ-1:0]       rd_data_valid_o, done_o, err_o;
  logic                     start_o, stop_o, write_o, read_o;
  logic [7:0]               SPI_Write_Data_o, SPI_CS_Reg_o, SPI_Read_Data_i;
  logic                     IRQ_write_i, IRQ_read_i, trnfer_cmplte_i;

  spi_txn_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .Bus_CLK_i(Bus_CLK_i), .RSTn_i(RSTn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cs_i(req_cs_i), .req_wr_len_i(req_wr_len_i), .req_rd_len_i(req_rd_len_i),
    .wr_data_i(wr_data_i), .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
    .done_o(done_o), .err_o(err_o),
    .start_o(start_o), .stop_o(stop_o), .write_o(write_o), .read_o(read_o),
    .SPI_Write_Data_o(SPI_Write_Data_o), .SPI_CS_Reg_o(SPI_CS_Reg_o),
    .IRQ_write_i(IRQ_write_i), .IRQ_read_i(IRQ_read_i),
    .trnfer_cmplte_i(trnfer_cmplte_i), .SPI_Read_Data_i(SPI_Read_Data_i)
  );

  always #5 Bus_CLK_i = ~Bus_CLK_i;

  int checks = 0;
  int passed = 0;

  logic [7:0] wq0[$], wq1[$], rd_tab[$], wlog[$], rlog[$];
  int         rsrc[$], done_log[$];
  int         start_cnt = 0, stop_cnt = 0, both_cnt = 0, err_cnt = 0;
  bit         start_prev = 1'b0, stop_prev = 1'b0, model_wr_en = 1'b1;

  // Serializer model, write-data feeder and output monitors, all acting on the falling edge.
  initial begin
    IRQ_write_i = 1'b0; IRQ_read_i = 1'b0; trnfer_cmplte_i = 1'b0;
    SPI_Read_Data_i = 8'h00; wr_data_valid_i = '0; wr_data_i = '0;
    forever begin
      @(negedge Bus_CLK_i);
      if (!RSTn_i) begin
        IRQ_write_i = 1'b0; IRQ_read_i = 1'b0; trnfer_cmplte_i = 1'b0;
      end else begin
        if (write_o && !IRQ_write_i && model_wr_en) begin
          wlog.push_back(SPI_Write_Data_o);
          IRQ_write_i = 1'b1;
        end else if (!write_o && IRQ_write_i) IRQ_write_i = 1'b0;
        if (read_o && !IRQ_read_i) begin
          SPI_Read_Data_i = (rd_tab.size() > 0) ? rd_tab.pop_front() : 8'hEE;
          IRQ_read_i = 1'b1;
        end else if (!read_o && IRQ_read_i) IRQ_read_i = 1'b0;
        if (stop_o && !trnfer_cmplte_i) trnfer_cmplte_i = 1'b1;
        else if (!stop_o && trnfer_cmplte_i) trnfer_cmplte_i = 1'b0;
      end
      if (start_o && !start_prev) start_cnt++;
      if (stop_o && !stop_prev) stop_cnt++;
      if (start_o && stop_o) both_cnt++;
      start_prev = start_o; stop_prev = stop_o;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (rd_data_valid_o[r]) begin rlog.push_back(rd_data_o); rsrc.push_back(r); end
        if (done_o[r]) done_log.push_back(r);
        if (err_o[r]) err_cnt++;
      end
      if (wr_data_ready_o[0] && wq0.size() > 0) void'(wq0.pop_front());
      if (wr_data_ready_o[1] && wq1.size() > 0) void'(wq1.pop_front());
      wr_data_valid_i[0] = (wq0.size() > 0);
      wr_data_valid_i[1] = (wq1.size() > 0);
      wr_data_i[7:0]     = (wq0.size() > 0) ? wq0[0] : 8'h00;
      wr_data_i[15:8]    = (wq1.size() > 0) ? wq1[0] : 8'h00;
    end
  end

  task automatic step();
    @(negedge Bus_CLK_i);
    #2;
  endtask

  task automatic clear_logs();
    wlog.delete(); rlog.delete(); rsrc.delete(); done_log.delete();
    start_cnt = 0; stop_cnt = 0;
  endtask

  task automatic do_reset();
    RSTn_i = 1'b0;
    req_valid_i = '0; req_cs_i = '0; req_wr_len_i = '0; req_rd_len_i = '0;
    wq0.delete(); wq1.delete(); rd_tab.delete();
    repeat (3) step();
    RSTn_i = 1'b1;
    step();
    clear_logs();
  endtask

  task automatic issue(input int r, input logic [7:0] cs, input logic [7:0] wl,
                       input logic [7:0] rl, output bit got);
    req_cs_i[r*8 +: 8]           = cs;
    req_wr_len_i[r*LEN_W +: LEN_W] = wl;
    req_rd_len_i[r*LEN_W +: LEN_W] = rl;
    req_valid_i[r] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (req_ready_o[r]) got = 1'b1;
    end
    req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, output bit got);
    got = (done_log.size() > n0);
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (done_log.size() > n0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    do_reset();
    outs = {req_ready_o, wr_data_ready_o, rd_data_valid_o, done_o, err_o,
            start_o, stop_o, write_o, read_o, SPI_Write_Data_o, SPI_CS_Reg_o, rd_data_o,
            4'h0};
    checks++;
    if (outs !== 48'h0) $display("FAIL reset_outputs got=%h exp=0", outs);
    else passed++;
  endtask

  task automatic test_write();
    bit got;
    do_reset();
    wq0.push_back(8'hA5); wq0.push_back(8'h3C);
    issue(0, 8'h01, 8'd2, 8'd0, got);
    checks++;
    if (got !== 1'b1) $display("FAIL wr_grant got=%0d exp=1", got); else passed++;
    checks++;
    if (SPI_CS_Reg_o !== 8'h01) $display("FAIL wr_cs got=%h exp=01", SPI_CS_Reg_o); else passed++;
    wait_done(0, 200, got);
    checks++;
    if (got !== 1'b1 || done_log[0] != 0) $display("FAIL wr_done got=%0d exp=1", got); else passed++;
    checks++;
    if (wlog.size() != 2 || {wlog[0], wlog[1]} !== 16'hA53C)
      $display("FAIL wr_bytes got_n=%0d exp=A5,3C", wlog.size());
    else passed++;
    checks++;
    if (start_cnt != 2 || stop_cnt != 1 || rlog.size() != 0)
      $display("FAIL wr_ctrl got start=%0d stop=%0d rd=%0d exp 2/1/0", start_cnt, stop_cnt, rlog.size());
    else passed++;
    step();
    checks++;
    if (SPI_CS_Reg_o !== 8'h00) $display("FAIL wr_cs_idle got=%h exp=00", SPI_CS_Reg_o); else passed++;
  endtask

  task automatic test_read();
    bit got;
    clear_logs();
    wq1.push_back(8'h9F);
    rd_tab.push_back(8'h11); rd_tab.push_back(8'h22); rd_tab.push_back(8'h33);
    issue(1, 8'h04, 8'd1, 8'd3, got);
    checks++;
    if (got !== 1'b1 || SPI_CS_Reg_o !== 8'h04) $display("FAIL rd_grant got=%0d cs=%h exp=1 04", got, SPI_CS_Reg_o);
    else passed++;
    wait_done(0, 300, got);
    checks++;
    if (got !== 1'b1 || done_log[0] != 1) $display("FAIL rd_done got=%0d exp=1", got); else passed++;
    checks++;
    if (wlog.size() != 1 || wlog[0] !== 8'h9F) $display("FAIL rd_wbyte got_n=%0d exp=9F", wlog.size());
    else passed++;
    checks++;
    if (rlog.size() != 3 || {rlog[0], rlog[1], rlog[2]} !== 24'h112233)
      $display("FAIL rd_bytes got_n=%0d exp=11,22,33", rlog.size());
    else passed++;
    checks++;
    if (rsrc.size() != 3 || rsrc[0] != 1 || rsrc[1] != 1 || rsrc[2] != 1)
      $display("FAIL rd_owner got_n=%0d exp=three pulses on 1", rsrc.size());
    else passed++;
    checks++;
    if (stop_cnt != 1 || start_cnt != 4) $display("FAIL rd_ctrl got start=%0d stop=%0d exp 4/1", start_cnt, stop_cnt);
    else passed++;
  endtask

  task automatic both_order(output int first, output int second);
    int order[$];
    req_cs_i = 16'h0802; req_wr_len_i = '0; req_rd_len_i = '0;
    req_valid_i = 2'b11;
    for (int i = 0; i < 40 && order.size() < 2; i++) begin
      step();
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_ready_o[r]) begin order.push_back(r); req_valid_i[r] = 1'b0; end
      end
    end
    req_valid_i = '0;
    first  = (order.size() > 0) ? order[0] : -1;
    second = (order.size() > 1) ? order[1] : -1;
    repeat (4) step();
  endtask

  task automatic test_round_robin();
    int a, b;
    bit got;
    do_reset();
    both_order(a, b);
    checks++;
    if (a != 0 || b != 1) $display("FAIL rr_first got=%0d,%0d exp=0,1", a, b); else passed++;
    issue(0, 8'h02, 8'd0, 8'd0, got);
    repeat (4) step();
    both_order(a, b);
    checks++;
    if (a != 1 || b != 0) $display("FAIL rr_rotate got=%0d,%0d exp=1,0", a, b); else passed++;
  endtask

  task automatic test_zero_len();
    bit got;
    clear_logs();
    issue(1, 8'h08, 8'd0, 8'd0, got);
    step();
    checks++;
    if (done_o !== 2'b10) $display("FAIL zero_done got=%b exp=10", done_o); else passed++;
    repeat (3) step();
    checks++;
    if (start_cnt != 0 || stop_cnt != 0) $display("FAIL zero_ctrl got start=%0d stop=%0d exp 0/0", start_cnt, stop_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [47:0] outs;
    int n;
    clear_logs();
    rd_tab.push_back(8'hAA); rd_tab.push_back(8'hBB);
    issue(0, 8'h01, 8'd0, 8'd2, got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (read_o) got = 1'b1;
    end
    checks++;
    if (got !== 1'b1) $display("FAIL mid_read_issue got=%0d exp=1", got); else passed++;
    RSTn_i = 1'b0;
    #1;
    outs = {req_ready_o, wr_data_ready_o, rd_data_valid_o, done_o, err_o,
            start_o, stop_o, write_o, read_o, SPI_Write_Data_o, SPI_CS_Reg_o, rd_data_o, 4'h0};
    checks++;
    if (outs !== 48'h0) $display("FAIL mid_reset_outputs got=%h exp=0", outs); else passed++;
    repeat (2) step();
    RSTn_i = 1'b1;
    rd_tab.delete();
    repeat (3) step();
    checks++;
    if (done_log.size() != 0) $display("FAIL mid_no_done got=%0d exp=0", done_log.size()); else passed++;
    n = wlog.size();
    wq1.push_back(8'h5A);
    issue(1, 8'h04, 8'd1, 8'd0, got);
    wait_done(0, 200, got);
    checks++;
    if (got !== 1'b1 || done_log[0] != 1 || wlog.size() != n + 1 || wlog[n] !== 8'h5A)
      $display("FAIL mid_after got=%0d exp=done on 1 with byte 5A", got);
    else passed++;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    int e0;
    do_reset();
    e0 = err_cnt;
    model_wr_en = 1'b0;
    wq0.push_back(8'h77);
    issue(0, 8'h01, 8'd1, 8'd0, got);
    wait_done(0, 70000, got);
    checks++;
    if (got !== 1'b1 || err_cnt != e0 + 1 || stop_cnt != 1)
      $display("FAIL timeout got done=%0d err=%0d stop=%0d exp 1/1/1", got, err_cnt - e0, stop_cnt);
    else passed++;
    model_wr_en = 1'b1;
    err_cnt = e0;
  endtask
`endif

  initial begin
    RSTn_i = 1'b0;
    req_valid_i = '0; req_cs_i = '0; req_wr_len_i = '0; req_rd_len_i = '0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_zero_len();
    test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (both_cnt != 0) $display("FAIL start_stop_overlap got=%0d exp=0", both_cnt); else passed++;
`ifndef SPI_ARB_TIMEOUT_EN
    checks++;
    if (err_cnt != 0) $display("FAIL err_without_watchdog got=%0d exp=0", err_cnt); else passed++;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
